// File: rtl/iddr_deser.sv
// DDR input deserialiser: both-edge fabric capture, framing into 2*RATIO-sample words, bitslip, auto-align FSM.
// Word with newest sample from the falling edge of cycle k strobes after posedge k+2; no backpressure.
`timescale 1ns/1ps
module iddr_deser #(
  parameter int WIDTH = 1,
  parameter int RATIO = 4,
  parameter logic [WIDTH*2*RATIO-1:0] ALIGN_PATTERN = 8'h5C
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         d,
  input  logic                     bitslip,
  input  logic                     align_en,
  output logic [WIDTH*2*RATIO-1:0] out_data,
  output logic                     out_valid,
  output logic                     locked,
  output logic                     align_fail
);

  localparam int N   = 2 * RATIO;
  localparam int DW  = WIDTH * N;
  localparam int SRW = WIDTH * (N + 1);
  localparam int PW  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int CW  = $clog2(N + 1);

  typedef enum logic [1:0] {SEEK, FLUSH, LOCKED} state_t;

  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;
  logic [SRW-1:0]   sr;
  logic [PW-1:0]    phase;
  logic             half;
  logic             stall;
  logic             emit;
  logic             slip;
  logic             int_slip;
  state_t           state;
  state_t           state_nxt;
  logic             locked_nxt;
  logic             fail_nxt;
  logic [CW-1:0]    slip_cnt;
  logic [CW-1:0]    cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rise_r <= '0;
    else     rise_r <= d;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) fall_r <= '0;
    else     fall_r <= d;
  end

  assign slip = align_en ? int_slip : bitslip;
  assign emit = (phase == PW'(RATIO - 1)) && !stall;

  // A slip with half=0 delays the next word by one cycle and takes it one sample
  // earlier; the delay is applied in the following cycle so a slip on an emit cycle
  // still lets that cycle's word out with the old framing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      phase     <= '0;
      half      <= 1'b0;
      stall     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      sr        <= {fall_r, rise_r, sr[SRW-1:2*WIDTH]};
      stall     <= slip && !half;
      if (slip) half <= ~half;
      if (!stall) phase <= (phase == PW'(RATIO - 1)) ? '0 : phase + PW'(1);
      out_valid <= emit;
      if (emit) out_data <= half ? sr[DW-1:0] : sr[SRW-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEEK;
      locked     <= 1'b0;
      align_fail <= 1'b0;
      slip_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      locked     <= locked_nxt;
      align_fail <= fail_nxt;
      slip_cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    locked_nxt = locked;
    fail_nxt   = align_fail;
    cnt_nxt    = slip_cnt;
    int_slip   = 1'b0;
    if (!align_en) begin
      state_nxt  = SEEK;
      locked_nxt = 1'b0;
      fail_nxt   = 1'b0;
      cnt_nxt    = '0;
    end else begin
      case (state)
        SEEK: begin
          if (out_valid) begin
            if (out_data == ALIGN_PATTERN) begin
              state_nxt  = LOCKED;
              locked_nxt = 1'b1;
            end else begin
              int_slip  = 1'b1;
              state_nxt = FLUSH;
              // Search keeps going after a full lap; the failure flag stays up.
              if (slip_cnt == CW'(N - 1)) begin
                cnt_nxt  = '0;
                fail_nxt = 1'b1;
              end else begin
                cnt_nxt = slip_cnt + CW'(1);
              end
            end
          end
        end
        FLUSH: begin
          if (out_valid) state_nxt = SEEK;
        end
        LOCKED: ;
        default: state_nxt = SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_iddr_deser.sv
// Bench: two deserialiser instances (1 lane x4, 2 lanes x1) against a sample-index framing model.
`timescale 1ns/1ps
module tb_iddr_deser;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       d_a, bs_a, ae_a, ov_a, lk_a, af_a;
  logic [7:0] od_a;
  logic [1:0] d_b;
  logic       bs_b, ae_b, ov_b, lk_b, af_b;
  logic [3:0] od_b;

  iddr_deser #(.WIDTH(1), .RATIO(4), .ALIGN_PATTERN(8'h5C)) dut_a (
    .clk(clk), .rst(rst), .d(d_a), .bitslip(bs_a), .align_en(ae_a),
    .out_data(od_a), .out_valid(ov_a), .locked(lk_a), .align_fail(af_a));

  iddr_deser #(.WIDTH(2), .RATIO(1), .ALIGN_PATTERN(4'h9)) dut_b (
    .clk(clk), .rst(rst), .d(d_b), .bitslip(bs_b), .align_en(ae_b),
    .out_data(od_b), .out_valid(ov_b), .locked(lk_b), .align_fail(af_b));

  int checks = 0;
  int failures = 0;

  // Stream sources: unit A repeats pat_a LSB-first, unit B alternates 01 (rise) / 10 (fall).
  logic [7:0] pat_a;
  int         off_a;
  logic [1:0] samp [2][4096];   // sample n stored at n+16; negative indices are reset zeros

  // Model state: e = index of newest sample of the next word of each unit.
  int         k;
  int         e [2];
  int         nsmp [2];
  logic       mv [2];
  logic [7:0] md [2];
  int         mst;              // 0 seek, 1 flush, 2 locked
  logic       mlk, maf;
  int         mcnt, slips_a;

  int first_a, last_a, gap_a, last_b, gap_b;
  logic [7:0] data_a, data_b;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=%h required=%h", nm, k, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=%0d required=%0d", nm, k, act, exp);
    end
  endtask

  function automatic logic sa(input int n);
    return pat_a[(n + off_a) % 8];
  endfunction

  function automatic logic [1:0] sb(input int n);
    return (n % 2 == 0) ? 2'b01 : 2'b10;
  endfunction

  // Word ending at sample ee is strobed after posedge floor(ee/2)+2.
  function automatic int emit_cyc(input int ee);
    return ((ee + 16) >>> 1) - 6;
  endfunction

  function automatic logic [7:0] word(input int u, input int ee);
    logic [7:0] w;
    w = '0;
    if (u == 0) begin
      for (int i = 0; i < 8; i++) w[i] = samp[0][ee - 7 + i + 16][0];
    end else begin
      for (int i = 0; i < 2; i++) w[2*i +: 2] = samp[1][ee - 1 + i + 16];
    end
    return w;
  endfunction

  task automatic model_reset();
    k = 0;
    nsmp[0] = 8; nsmp[1] = 2;
    e[0] = 2*4 - 5; e[1] = 2*1 - 5;
    for (int u = 0; u < 2; u++) begin mv[u] = 1'b0; md[u] = '0; end
    mst = 0; mlk = 1'b0; maf = 1'b0; mcnt = 0;
    first_a = -1; last_a = -100; gap_a = 0; last_b = -100; gap_b = 0;
  endtask

  task automatic model_edge();
    bit sl [2];
    sl[0] = 1'b0;
    if (!ae_a) begin
      mst = 0; mlk = 1'b0; maf = 1'b0; mcnt = 0;
      sl[0] = bs_a;
    end else if (mst == 0 && mv[0]) begin
      if (md[0] == 8'h5C) begin
        mst = 2; mlk = 1'b1;
      end else begin
        sl[0] = 1'b1; slips_a++; mcnt++;
        if (mcnt == 8) begin maf = 1'b1; mcnt = 0; end
        mst = 1;
      end
    end else if (mst == 1 && mv[0]) begin
      mst = 0;
    end
    sl[1] = bs_b;
    for (int u = 0; u < 2; u++) begin
      if (k == emit_cyc(e[u])) begin
        mv[u] = 1'b1; md[u] = word(u, e[u]); e[u] += nsmp[u];
      end else begin
        mv[u] = 1'b0;
      end
      if (sl[u]) e[u] += 1;
    end
  endtask

  task automatic compare();
    chk("valid_a", 8'(ov_a), 8'(mv[0]));
    chk("data_a", od_a, md[0]);
    chk("locked_a", 8'(lk_a), 8'(mlk));
    chk("fail_a", 8'(af_a), 8'(maf));
    chk("valid_b", 8'(ov_b), 8'(mv[1]));
    chk("data_b", 8'(od_b), md[1]);
    if (ov_a) begin
      if (first_a < 0) first_a = k;
      gap_a = k - last_a; last_a = k; data_a = od_a;
    end
    if (ov_b) begin gap_b = k - last_b; last_b = k; data_b = 8'(od_b); end
  endtask

  // One clock: rise sample before posedge, fall sample before negedge, check after negedge.
  task automatic step();
    int n;
    n = 2 * k;
    if (n + 17 >= 4096) begin
      $display("FAIL sample_buffer k=%0d actual=%0d required=<4096", k, n + 17);
      $fatal(1);
    end
    d_a = sa(n); d_b = sb(n);
    samp[0][n + 16] = {1'b0, d_a}; samp[1][n + 16] = d_b;
    @(posedge clk); #1;
    model_edge();
    d_a = sa(n + 1); d_b = sb(n + 1);
    samp[0][n + 17] = {1'b0, d_a}; samp[1][n + 17] = d_b;
    @(negedge clk); #1;
    compare();
    k++;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear with no clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_valid_a", 8'(ov_a), 8'h00);
    chk("rst_data_a", od_a, 8'h00);
    chk("rst_locked_a", 8'(lk_a), 8'h00);
    chk("rst_fail_a", 8'(af_a), 8'h00);
    chk("rst_valid_b", 8'(ov_b), 8'h00);
    chk("rst_data_b", 8'(od_b), 8'h00);
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; d_a = 1'b0; d_b = 2'b00; bs_a = 1'b0; bs_b = 1'b0; ae_a = 1'b0; ae_b = 1'b0;
    pat_a = 8'h5C; off_a = 4; slips_a = 0;
    for (int i = 0; i < 16; i++) begin samp[0][i] = '0; samp[1][i] = '0; end
    model_reset();
    @(negedge clk); #1;
    do_reset();

    // First strobe on the 4th posedge after release, then every 4 cycles; aligned words read 5C.
    repeat (12) step();
    chk_i("first_strobe", first_a, 3);
    chk_i("strobe_period", gap_a, 4);
    repeat (16) step();
    chk("word_5c", data_a, 8'h5C);
    chk("b_word", data_b, 8'h09);
    chk_i("b_period", gap_b, 1);

    // Single bitslip just after a strobe: 5-cycle gap, then boundary +1 sample.
    for (int i = 0; i < 8 && !ov_a; i++) step();
    bs_a = 1'b1; step(); bs_a = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); if (ov_a) break; end
    chk_i("slip_gap", gap_a, 5);
    repeat (8) step();
    chk("word_2e", data_a, 8'h2E);
    // Seven more slips, including back-to-back pulses and slips on emit cycles.
    for (int i = 0; i < 7; i++) begin
      bs_a = 1'b1; step(); bs_a = 1'b0;
      if (i != 1 && i != 4) repeat (2 + i) step();
    end
    repeat (12) step();
    chk("word_5c_after8", data_a, 8'h5C);

    // Two-lane, one-cycle-per-word unit: slip with half=0 drops one strobe.
    bs_b = 1'b1; step(); bs_b = 1'b0;
    chk("b_slip_cycle_word", 8'(od_b), 8'h09);
    step();
    chk("b_skip", 8'(ov_b), 8'h00);
    step();
    chk("b_word_slipped", data_b, 8'h06);
    chk_i("b_gap", gap_b, 2);
    bs_b = 1'b1; step(); bs_b = 1'b0;
    chk("b_noskip", 8'(ov_b), 8'h01);
    step();
    chk("b_word_back", data_b, 8'h09);
    chk_i("b_gap_back", gap_b, 1);

    // Auto-align on a stream three samples off.
    do_reset();
    off_a = 1; ae_a = 1'b1; slips_a = 0;
    for (int i = 0; i < 200 && !lk_a; i++) step();
    chk("lock_reached", 8'(lk_a), 8'h01);
    chk_i("lock_slips", slips_a, 3);
    repeat (8) step();
    chk("locked_word", data_a, 8'h5C);
    chk("locked_nofail", 8'(af_a), 8'h00);
    bs_a = 1'b1; step(); bs_a = 1'b0;
    repeat (8) step();
    chk("locked_ignores_bitslip", data_a, 8'h5C);
    step(); step();

    // Reset mid-word while locked.
    do_reset();

    // Constant zero stream never locks; failure after one full lap of slips.
    pat_a = 8'h00; ae_a = 1'b1; slips_a = 0;
    for (int i = 0; i < 300 && !af_a; i++) step();
    chk("align_fail_set", 8'(af_a), 8'h01);
    chk_i("fail_after_8", slips_a, 8);
    chk("fail_not_locked", 8'(lk_a), 8'h00);
    repeat (6) step();
    ae_a = 1'b0; step();
    chk("fail_cleared", 8'(af_a), 8'h00);
    chk("lock_cleared", 8'(lk_a), 8'h00);
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
